aes_sub_bytes_seq: RTL and testbench

Iterative forward AES SubBytes engine for the encryption datapath; it is the forward counterpart of the decryption-side inverse substitution. It accepts a 128-bit state over a valid/ready handshake. It substitutes the state through a shared bank of `LANES` forward S-boxes, `LANES` bytes per cycle, and presents the result on a valid/ready output. The optional ShiftRows fold lets the round logic take the output directly.

---
 rtl/aes_sub_bytes_seq_if.sv | 20 ++
 rtl/aes_sub_bytes_seq.sv | 131 +++++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/aes_sub_bytes_seq_if.sv
// Handshake bundle for aes_sub_bytes_seq: input state channel and result channel.
// master = producer/consumer side, slave = the engine.
interface aes_sub_bytes_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_sub_bytes_seq.sv
// Iterative forward AES SubBytes engine, LANES bytes per cycle through shared S-boxes.
// Optional ShiftRows fold on the output enabled by defining AES_SUBBYTES_SHIFTROWS_EN.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [7:0] TBL [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign y = TBL[a];
endmodule

module aes_sub_bytes_seq #(
   parameter int unsigned LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_sub_bytes_seq_if.slave   bus,
   output logic                 busy
);
   localparam int unsigned N  = 16 / LANES;
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] LAST = PW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] pass, pass_nx;
   logic [7:0]    work    [16];
   logic [7:0]    work_nx [16];
   logic [7:0]    in_bytes [16];
   logic [7:0]    lane_in  [LANES];
   logic [7:0]    lane_out [LANES];
   logic [3:0]    lane_idx [LANES];
   int unsigned   base;

   for (genvar g = 0; g < 16; g++) begin : g_bytes
      localparam int unsigned R = g % 4;
      localparam int unsigned C = g / 4;
      assign in_bytes[g] = bus.in_data[127-8*g -: 8];
`ifdef AES_SUBBYTES_SHIFTROWS_EN
      assign bus.out_data[127-8*g -: 8] = work[4*((C + R) % 4) + R];
`else
      assign bus.out_data[127-8*g -: 8] = work[g];
`endif
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      aes_sbox u_sbox (.a(lane_in[g]), .y(lane_out[g]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pass  <= '0;
         work  <= '{default: '0};
      end else begin
         state <= state_nx;
         pass  <= pass_nx;
         work  <= work_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      pass_nx       = pass;
      work_nx       = work;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
      base          = 32'(pass) * LANES;
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_idx[l] = 4'(base + l);
         lane_in[l]  = work[lane_idx[l]];
      end

      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               work_nx  = in_bytes;
               pass_nx  = '0;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            for (int unsigned l = 0; l < LANES; l++) begin
               work_nx[lane_idx[l]] = lane_out[l];
            end
            // pass holds at LAST when leaving RUN; it is reloaded on the next accept
            if (pass == LAST) begin
               state_nx = DONE;
            end else begin
               pass_nx = pass + 1'b1;
            end
         end
         DONE: begin
            busy          = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               bus.in_ready = 1'b1;
               if (bus.in_valid) begin
                  work_nx  = in_bytes;
                  pass_nx  = '0;
                  state_nx = RUN;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq: LANES=4 main instance plus LANES=1 and LANES=16 instances.
// Expected ShiftRows-folded results are selected with AES_SUBBYTES_SHIFTROWS_EN.
module tb_aes_sub_bytes_seq;
   localparam logic [127:0] VEC   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] ZEROS = 128'h0;
   localparam logic [127:0] ONES  = {16{8'hff}};
   localparam logic [127:0] S63   = {16{8'h63}};
   localparam logic [127:0] S16   = {16{8'h16}};
`ifdef AES_SUBBYTES_SHIFTROWS_EN
   localparam logic [127:0] EXP_VEC = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] EXP_SEQ = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
`else
   localparam logic [127:0] EXP_VEC = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] EXP_SEQ = 128'h637c777bf26b6fc53001672bfed7ab76;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic busy4, busy1, busy16;
   int   checks = 0;
   int   failures = 0;
   int   lat, lat1, lat16;

   aes_sub_bytes_seq_if a ();
   aes_sub_bytes_seq_if b1 ();
   aes_sub_bytes_seq_if b16 ();

   aes_sub_bytes_seq #(.LANES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(a.slave),   .busy(busy4));
   aes_sub_bytes_seq #(.LANES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1.slave),  .busy(busy1));
   aes_sub_bytes_seq #(.LANES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave), .busy(busy16));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a state at the current negedge, let it be taken on the next rising edge.
   task automatic accept4(input logic [127:0] d);
      a.in_valid = 1'b1;
      a.in_data  = d;
      #1;
      check("accept_in_ready", 128'(a.in_ready), 128'd1);
      @(posedge clk);
      @(negedge clk);
      a.in_valid = 1'b0;
      #1;
      check("run_busy", 128'(busy4), 128'd1);
      check("run_in_ready", 128'(a.in_ready), 128'd0);
      check("run_out_valid", 128'(a.out_valid), 128'd0);
   endtask

   task automatic wait_out4(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (a.out_valid !== 1'b1 && n < 40);
   endtask

   task automatic hold5(input logic [127:0] exp, input string tag);
      repeat (5) begin
         @(negedge clk);
         #1;
         check({tag, "_hold_data"}, a.out_data, exp);
         check({tag, "_hold_valid"}, 128'(a.out_valid), 128'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "simulation timeout");
   end

   initial begin
      rst_n = 1'b0;
      a.in_valid = 1'b0;   a.in_data = '0;   a.out_ready = 1'b0;
      b1.in_valid = 1'b0;  b1.in_data = '0;  b1.out_ready = 1'b0;
      b16.in_valid = 1'b0; b16.in_data = '0; b16.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 128'(a.in_ready), 128'd1);
      check("rst_out_valid", 128'(a.out_valid), 128'd0);
      check("rst_busy", 128'(busy4), 128'd0);
      check("rst_out_data", a.out_data, ZEROS);
      check("rst_busy_l1", 128'(busy1), 128'd0);
      check("rst_busy_l16", 128'(busy16), 128'd0);

      // Single block, held with out_ready low while a new request is offered
      @(negedge clk);
      accept4(VEC);
      wait_out4(lat);
      check("vec_latency", 128'(lat), 128'd4);
      check("vec_data", a.out_data, EXP_VEC);
      a.in_valid = 1'b1;
      a.in_data  = ONES;
      #1;
      check("done_stall_in_ready", 128'(a.in_ready), 128'd0);
      hold5(EXP_VEC, "vec");
      a.in_valid  = 1'b0;
      a.out_ready = 1'b1;
      #1;
      check("done_release_in_ready", 128'(a.in_ready), 128'd1);
      @(negedge clk);
      a.out_ready = 1'b0;
      #1;
      check("idle_out_valid", 128'(a.out_valid), 128'd0);
      check("idle_busy", 128'(busy4), 128'd0);

      // All-zero block, then back-to-back all-ff block
      @(negedge clk);
      accept4(ZEROS);
      wait_out4(lat);
      check("zero_latency", 128'(lat), 128'd4);
      check("zero_data", a.out_data, S63);
      hold5(S63, "zero");
      a.out_ready = 1'b1;
      a.in_valid  = 1'b1;
      a.in_data   = ONES;
      #1;
      check("b2b_in_ready", 128'(a.in_ready), 128'd1);
      @(posedge clk);
      @(negedge clk);
      a.in_valid  = 1'b0;
      a.out_ready = 1'b0;
      #1;
      check("b2b_out_valid", 128'(a.out_valid), 128'd0);
      check("b2b_busy", 128'(busy4), 128'd1);
      wait_out4(lat);
      check("ff_latency", 128'(lat), 128'd4);
      check("ff_data", a.out_data, S16);
      a.out_ready = 1'b1;
      @(negedge clk);
      a.out_ready = 1'b0;

      // Reset two cycles into RUN discards the block
      @(negedge clk);
      accept4(VEC);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 128'(a.out_valid), 128'd0);
      check("abort_busy", 128'(busy4), 128'd0);
      check("abort_out_data", a.out_data, ZEROS);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1;
         check("abort_no_valid", 128'(a.out_valid), 128'd0);
      end
      check("abort_in_ready", 128'(a.in_ready), 128'd1);
      check("abort_data_zero", a.out_data, ZEROS);

      // LANES=1 and LANES=16 accept the same block on the same edge
      @(negedge clk);
      b1.in_valid  = 1'b1;  b1.in_data  = SEQ;
      b16.in_valid = 1'b1;  b16.in_data = SEQ;
      @(posedge clk);
      @(negedge clk);
      b1.in_valid  = 1'b0;
      b16.in_valid = 1'b0;
      lat1  = 0;
      lat16 = 0;
      for (int c = 1; c <= 40 && (lat1 == 0 || lat16 == 0); c++) begin
         @(negedge clk);
         if (b1.out_valid === 1'b1 && lat1 == 0)   lat1 = c;
         if (b16.out_valid === 1'b1 && lat16 == 0) lat16 = c;
      end
      check("l1_latency", 128'(lat1), 128'd16);
      check("l16_latency", 128'(lat16), 128'd1);
      check("l1_data", b1.out_data, EXP_SEQ);
      check("l16_data", b16.out_data, EXP_SEQ);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
